// File: rtl/rb_link_pkg.sv
// Constants and FSM encoding shared by the RB1 serializer and the RB2 packet receiver.
package rb_link_pkg;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 18;
  localparam int NUM_PKT  = 8;
  localparam int PKT_BITS = ADDR_W + DATA_W;
  // Bit counter must reach PKT_BITS+1 (overflow marker).
  localparam int CNT_W    = $clog2(PKT_BITS + 2);
  localparam int PCNT_W   = $clog2(NUM_PKT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } rx_state_e;
endpackage

// File: rtl/serial_packet_receiver_if.sv
// Serial link input plus RB2 single-port write interface.
interface serial_packet_receiver_if
  import rb_link_pkg::*;
  ;
  logic              sen;
  logic              sd;
  logic              RB2_RW;
  logic [ADDR_W-1:0] RB2_A;
  logic [DATA_W-1:0] RB2_D;
  logic [DATA_W-1:0] RB2_Q;
  logic              done;

  modport master (output sen, sd, RB2_Q, input RB2_RW, RB2_A, RB2_D, done);
  modport slave  (input sen, sd, RB2_Q, output RB2_RW, RB2_A, RB2_D, done);
endinterface

// File: rtl/rx_shifter.sv
// Deserializer: shift register, saturating bit counter and overflow flag for one frame.
module rx_shifter
  import rb_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sen,
  input  logic              sd,
  output logic              frame_end,
  output logic              frame_ok,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  logic [PKT_BITS-1:0] shift;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;

  // Any nonzero count means a frame is open; the first sen=1 sample closes it.
  assign frame_end = en && sen && (cnt != '0);
  assign frame_ok  = (cnt == CNT_W'(PKT_BITS)) && !ovf;
  assign addr      = shift[PKT_BITS-1:DATA_W];
  assign data      = shift[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (!sen) begin
        shift <= {shift[PKT_BITS-2:0], sd};
        if (cnt != CNT_W'(PKT_BITS + 1)) cnt <= cnt + 1'b1;
        if (cnt >= CNT_W'(PKT_BITS)) ovf <= 1'b1;
      end else begin
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_packet_receiver.sv
// Receives framed serial packets and writes each valid one into RB2; flags done after NUM_PKT writes.
module serial_packet_receiver
  import rb_link_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  serial_packet_receiver_if.slave bus
);
  rx_state_e         state, nxt;
  logic [PCNT_W-1:0] pkt_cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic              frame_end, frame_ok, shift_en, commit, last;
  logic [ADDR_W-1:0] sh_addr;
  logic [DATA_W-1:0] sh_data;
  logic              rb2_q_unused;

  assign rb2_q_unused = ^bus.RB2_Q;

  assign last     = (pkt_cnt == PCNT_W'(NUM_PKT));
  // Freeze the shifter from the final write onward so late frames leave no trace.
  assign shift_en = (state != ST_DONE) && !((state == ST_COMMIT) && last);
  assign commit   = (state == ST_RECV) && frame_end && frame_ok;

  rx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .sen       (bus.sen),
    .sd        (bus.sd),
    .frame_end (frame_end),
    .frame_ok  (frame_ok),
    .addr      (sh_addr),
    .data      (sh_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (!bus.sen) nxt = ST_RECV;
      ST_RECV:   if (frame_end) nxt = frame_ok ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: nxt = last ? ST_DONE : (bus.sen ? ST_IDLE : ST_RECV);
      ST_DONE:   nxt = ST_DONE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.RB2_RW = (state != ST_COMMIT);
    bus.done   = (state == ST_DONE);
    bus.RB2_A  = a_q;
    bus.RB2_D  = d_q;
  end

  // Commit registers are decoupled from the shifter so the next frame can start immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      d_q     <= '0;
      pkt_cnt <= '0;
    end else if (commit) begin
      a_q     <= sh_addr;
      d_q     <= sh_data;
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_packet_receiver.sv
// Scoreboard bench for serial_packet_receiver: expected writes queued at frame end, checked on RB2_RW=0.
module tb_serial_packet_receiver;
  import rb_link_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  int   nwr = 0;
  int   npush = 0;
  exp_t sb[$];

  logic [DATA_W-1:0] dtab[8] = '{18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555,
                                 18'h00000, 18'h3F00F, 18'h12345, 18'h0ABCD};

  serial_packet_receiver_if bus();

  serial_packet_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write monitor: every RB2_RW=0 cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.RB2_RW === 1'b0) begin
      nwr++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(bus.RB2_A), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.RB2_A), 32'(e.a));
        chk("wr_data", 32'(bus.RB2_D), 32'(e.d));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sen = 1'b1;
    bus.sd = 1'b0;
    #1;
    chk("rst_rw", 32'(bus.RB2_RW), 1);
    chk("rst_a", 32'(bus.RB2_A), 0);
    chk("rst_d", 32'(bus.RB2_D), 0);
    chk("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
  endtask

  // Send nbits of {a,d} MSB first (random padding past 21), one idle gap cycle.
  // rst_bit >= 0 asserts reset at that bit instead of finishing the frame.
  task automatic send_pkt(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int nbits, input int rst_bit);
    logic [PKT_BITS-1:0] v;
    exp_t e;
    v = {a, d};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == rst_bit) begin
        rst = 1'b1;
        bus.sen = 1'b1;
        #1;
        chk("midrst_rw", 32'(bus.RB2_RW), 1);
        chk("midrst_a", 32'(bus.RB2_A), 0);
        chk("midrst_d", 32'(bus.RB2_D), 0);
        chk("midrst_done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        return;
      end
      bus.sen = 1'b0;
      bus.sd = (i < PKT_BITS) ? v[PKT_BITS-1-i] : 1'($urandom_range(1));
    end
    @(negedge clk);
    bus.sen = 1'b1;
    bus.sd = 1'b0;
    if (nbits == PKT_BITS && model_cnt < NUM_PKT) begin
      e.a = a;
      e.d = d;
      e.cyc = cyc + 1;
      sb.push_back(e);
      npush++;
      model_cnt++;
      if (model_cnt == NUM_PKT) begin
        @(negedge clk);
        chk("done_not_early", 32'(bus.done), 0);
        @(negedge clk);
        chk("done_set", 32'(bus.done), 1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sen = 1'b1;
    bus.sd = 1'b0;
    bus.RB2_Q = '0;
    do_reset();

    // Eight back-to-back packets, addresses 0..7
    for (int i = 0; i < 8; i++) send_pkt(ADDR_W'(i), dtab[i], PKT_BITS, -1);
    idle(3);
    chk("done_sticky", 32'(bus.done), 1);

    // Single packet, address 101, data 15555; values must hold afterwards
    do_reset();
    send_pkt(3'b101, 18'h15555, PKT_BITS, -1);
    idle(5);
    chk("hold_a", 32'(bus.RB2_A), 5);
    chk("hold_d", 32'(bus.RB2_D), 32'h15555);
    chk("hold_rw", 32'(bus.RB2_RW), 1);

    // Short, long, then valid frame: only the last one writes
    do_reset();
    send_pkt(3'd1, 18'h11111, PKT_BITS - 1, -1);
    send_pkt(3'd2, 18'h22222, PKT_BITS + 2, -1);
    send_pkt(3'd3, 18'h0BEEF, PKT_BITS, -1);
    idle(4);
    chk("pkt_cnt_after_bad", 32'(dut.pkt_cnt), 1);
    chk("no_done_yet", 32'(bus.done), 0);

    // Duplicate address 6, then six more; then two frames after done
    do_reset();
    send_pkt(3'd6, 18'h00FF0, PKT_BITS, -1);
    send_pkt(3'd6, 18'h3F00F, PKT_BITS, -1);
    for (int i = 0; i < 6; i++) send_pkt(ADDR_W'(i), dtab[7-i], PKT_BITS, -1);
    send_pkt(3'd7, 18'h1AAAA, PKT_BITS, -1);
    send_pkt(3'd2, 18'h05A5A, PKT_BITS, -1);
    idle(4);
    chk("done_after_extra", 32'(bus.done), 1);
    chk("rw_after_extra", 32'(bus.RB2_RW), 1);
    chk("cnt_frozen", 32'(dut.pkt_cnt), NUM_PKT);

    // Reset on bit 10 of packet 4, then a full sequence
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(ADDR_W'(i), dtab[i], PKT_BITS, -1);
    send_pkt(3'd3, 18'h3C3C3, PKT_BITS, 10);
    idle(2);
    chk("midrst_no_done", 32'(bus.done), 0);
    for (int i = 0; i < 8; i++) send_pkt(ADDR_W'(7 - i), dtab[i] ^ 18'h0F0F0, PKT_BITS, -1);
    idle(4);

    chk("sb_empty", sb.size(), 0);
    chk("write_count", nwr, npush);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_packet_receiver.md
Name: serial_packet_receiver

Overview:
- Downstream stage of the RB1 serializer. Receives framed serial packets on `sen`/`sd`.
- Each packet carries a 3-bit word address followed by an 18-bit data word. The block deserializes it and writes the word into register bank RB2 through a single-port read/write interface.
- After NUM_PKT valid packets have been written, it asserts `done`.

Parameters:
- ADDR_W, 3, header address bits per packet; also RB2 address width.
- DATA_W, 18, payload bits per packet; also RB2 word width.
- NUM_PKT, 8, valid packets to write before `done` asserts.

Ports:
- clk  in  1  single clock. All logic is posedge.
- rst  in  1  asynchronous, active-high reset.
- sen  in  1  frame enable, active low. High = idle/gap. Launched by the upstream stage on negedge clk.
- sd  in  1  serial data, MSB first. Valid while `sen`=0. Launched on negedge clk.
- RB2_RW  out  1  RB2 control: 1 = read/idle, 0 = write.
- RB2_A  out  ADDR_W  RB2 address.
- RB2_D  out  DATA_W  RB2 write data.
- RB2_Q  in  DATA_W  RB2 read data. Unused; kept for interface completeness.
- done  out  1  all NUM_PKT packets written. Sticky.

Behaviour:
- Reset values: RB2_RW=1, RB2_A=0, RB2_D=0, done=0. Bit counter, packet counter, shift register and overflow flag all clear.
- Sampling: `sen`/`sd` are sampled on posedge, half a cycle after the upstream negedge launch. No synchronizer is required.
- Packet frame: a maximal run of posedge samples with `sen`=0.
  - The first ADDR_W bits form the address, MSB first.
  - The next DATA_W bits form the data, MSB first.
  - A valid packet is exactly ADDR_W+DATA_W = 21 bits.
- Receive path:
  - Each posedge with `sen`=0: shift `sd` into a 21-bit shift register and increment the bit counter. The counter saturates at 22.
  - A count of 22 sets the overflow flag.
- Commit:
  - At the first posedge where `sen`=1 after a frame, with count==21 and no overflow: register RB2_A = shift[20:18], RB2_D = shift[17:0], RB2_RW=0.
  - RB2_RW=0 is held for exactly one cycle, then returns to 1.
  - The packet counter increments on the same edge.
  - At that same edge the bit counter and overflow flag clear.
- Malformed frame (count<21 or overflow): discard silently. No write; the packet counter is unchanged; the counter and flag clear.
- Back-to-back frames:
  - The upstream stage may leave `sen` high for only one cycle between packets.
  - The commit registers are separate from the shift register, so the next frame may begin shifting on the posedge immediately after the commit edge.
  - No bit may be lost.
- RB2_A and RB2_D hold their last written values while RB2_RW=1.
- done:
  - Set on the posedge after the write cycle in which the packet counter reaches NUM_PKT.
  - Stays 1 until reset.
  - Once done=1, later frames are ignored: no writes, counters frozen.
- Duplicate addresses: a later packet overwrites the earlier one. It still counts toward NUM_PKT.
- Reset mid-frame: everything clears immediately (async). The next `sen` falling edge starts a fresh frame.
- State machine:
  - IDLE (`sen`=1, no pending frame)
  - RECV (`sen`=0)
  - COMMIT (one cycle, RB2_RW=0)
  - DONE (terminal)
- Transitions:
  - IDLE→RECV on `sen`=0.
  - RECV→COMMIT on `sen`=1 with a valid count.
  - RECV→IDLE on `sen`=1 with an invalid count.
  - COMMIT→RECV if `sen`=0 at that edge, else →IDLE. If that was the NUM_PKT-th write, COMMIT→DONE instead.
  - DONE→DONE.

Decomposition:
- Shared package `rb_link_pkg`: ADDR_W, DATA_W, NUM_PKT, PKT_BITS (= ADDR_W+DATA_W), and the state enum encoding. The same constants are used by the upstream serializer.
- Sub-module `rx_shifter`:
  - Shift register, saturating bit counter and overflow flag.
  - Outputs: frame_end pulse, frame_ok, addr, data.
- The top level holds the FSM, commit registers, packet counter and `done`.

Test Plan:
- Reset, then 8 back-to-back packets with 1-cycle `sen` gaps, addresses 0..7, data 18'h3FFFF, 18'h00001, 18'h2AAAA, …
  - Expect exactly 8 single-cycle RB2_RW=0 pulses with the matching A/D.
  - Expect `done`=1 the cycle after the 8th write.
- Single packet, bits 101 followed by 18'h15555:
  - Expect RB2_A=5, RB2_D=18'h15555.
  - Expect RB2_RW=0 exactly at the posedge after `sen` rises.
- Short frame (20 bits), then a long frame (23 bits), then a valid frame at address 3:
  - Expect only one write (A=3). Packet counter=1.
- Two valid packets both at address 6 (data 18'h00FF0 then 18'h3F00F) plus 6 others:
  - Expect the last write to A=6 to carry 18'h3F00F.
  - Expect `done` after the 8th packet.
- Assert `rst` on bit 10 of packet 4:
  - Expect outputs at reset values immediately and no write for that packet.
  - A subsequent full 8-packet sequence completes with `done`.
- After `done`, send 2 more valid packets:
  - Expect RB2_RW stays 1 and `done` stays 1.
